// File: rtl/wimax_deinterleaver_pkg.sv
// Shared constants and reference vectors for the WiMAX QPSK-1/2 block deinterleaver
// (Ncbps=192, d=16, s=1).
package wimax_deinterleaver_pkg;

  localparam int NCBPS      = 192;
  localparam int DEINT_D    = 16;
  localparam int DEINT_ROWS = 12;
  localparam int ADDR_W     = 8;

  localparam logic [3:0]        ROW_LAST  = 4'(DEINT_ROWS - 1);
  localparam logic [3:0]        COL_LAST  = 4'(DEINT_D - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = 8'(NCBPS - 1);

  typedef logic [NCBPS-1:0] block_t;

  // Stream order is MSB first: stream bit i is vector bit NCBPS-1-i.
  localparam block_t FEC_ENDODER_OUTPUT =
    192'hA5C3_1F0E_96D2_4B78_E1C3_5A0F_3C96_D2E7_1B4F_8A60_C59E_27D3;

  function automatic block_t interleave(input block_t fec);
    block_t v;
    int     k;
    v = '0;
    for (int j = 0; j < NCBPS; j++) begin
      k = DEINT_D * (j % DEINT_ROWS) + j / DEINT_ROWS;
      v[NCBPS-1-j] = fec[NCBPS-1-k];
    end
    return v;
  endfunction

  localparam block_t INTERLEAVER_OUTPUT = interleave(FEC_ENDODER_OUTPUT);

endpackage

// File: rtl/wimax_deinterleaver_if.sv
// Serial bit-stream handshake bundle: upstream input side plus downstream output side.
interface wimax_deinterleaver_if;

  logic data_in;
  logic valid_in;
  logic ready_out;
  logic data_out;
  logic valid_out;
  logic ready_in;

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out
  );

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out
  );

endinterface

// File: rtl/deint_bank_ram.sv
// Two 192x1 ping-pong banks: one write port and one asynchronous read port, each with
// its own bank select. Contents are not reset.
module deint_bank_ram
  import wimax_deinterleaver_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_wr_bank,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_wr_data,
  input  logic              i_rd_bank,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_data
);

  logic [NCBPS-1:0] r_mem [2];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_bank][i_rd_addr];

endmodule

// File: rtl/wimax_deinterleaver.sv
// WiMAX QPSK-1/2 deinterleaver: writes bit j to k = 16*(j mod 12) + j/12 and drains
// each full bank in ascending k through a registered valid/ready output stage.
module wimax_deinterleaver
  import wimax_deinterleaver_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_N,
  wimax_deinterleaver_if.slave  bus
);

  logic [3:0]        r_row;
  logic [3:0]        r_col;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [1:0]        r_full;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_data_out;
  logic              r_valid_out;

  logic              w_ready;
  logic              w_wr_en;
  logic              w_wr_last;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_load;
  logic              w_rd_last;
  logic              w_rd_data;
  logic [1:0]        w_full_nxt;

  assign w_ready   = ~r_full[r_wr_bank];
  assign w_wr_en   = bus.valid_in & w_ready;
  assign w_wr_last = (r_row == ROW_LAST) && (r_col == COL_LAST);
  // With d = 16, k = 16*r + c is just the row counter above the column counter.
  assign w_wr_addr = {r_row, r_col};

  // Fetch into the output register whenever it is empty or being consumed this cycle.
  assign w_load    = r_full[r_rd_bank] & (~r_valid_out | bus.ready_in);
  assign w_rd_last = (r_rd_addr == ADDR_LAST);

  // A bank that finishes filling and the other bank releasing its last bit are always
  // different banks, so both updates can land in the same cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_en && w_wr_last) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_load && w_rd_last) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_row     <= '0;
      r_col     <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_wr_en) begin
      if (r_row == ROW_LAST) begin
        r_row <= '0;
        r_col <= w_wr_last ? 4'd0 : r_col + 4'd1;
      end else begin
        r_row <= r_row + 4'd1;
      end
      if (w_wr_last) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_full <= '0;
    end else begin
      r_full <= w_full_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_rd_addr   <= '0;
      r_rd_bank   <= 1'b0;
      r_data_out  <= 1'b0;
      r_valid_out <= 1'b0;
    end else if (w_load) begin
      r_data_out  <= w_rd_data;
      r_valid_out <= 1'b1;
      if (w_rd_last) begin
        r_rd_addr <= '0;
        r_rd_bank <= ~r_rd_bank;
      end else begin
        r_rd_addr <= r_rd_addr + 8'd1;
      end
    end else if (bus.ready_in) begin
      r_valid_out <= 1'b0;
    end
  end

  deint_bank_ram u_bank_ram (
    .clk       (clk),
    .i_we      (w_wr_en),
    .i_wr_bank (r_wr_bank),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (bus.data_in),
    .i_rd_bank (r_rd_bank),
    .i_rd_addr (r_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign bus.ready_out = w_ready;
  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;

endmodule

// File: tb/tb_wimax_deinterleaver.sv
// Bench for wimax_deinterleaver: streams blocks under directed and random handshakes and
// checks them against FEC_ENDODER_OUTPUT or a gather-form deinterleaving model.
module tb_wimax_deinterleaver;
  import wimax_deinterleaver_pkg::*;

  logic clk = 1'b0;
  logic reset_N = 1'b1;
  always #5 clk = ~clk;

  wimax_deinterleaver_if bus ();

  wimax_deinterleaver dut (
    .clk     (clk),
    .reset_N (reset_N),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  bit tx_q[$];
  bit rx_q[$];
  int unsigned p_valid = 100;
  int unsigned p_ready = 100;

  logic s_vo, s_do, s_ro, s_ri, s_vi;
  bit   s_acc, s_xfer;

  task automatic drive();
    bus.valid_in = (tx_q.size() > 0) && ($urandom_range(0, 99) < p_valid);
    bus.data_in  = (tx_q.size() > 0) ? tx_q[0] : 1'b0;
    bus.ready_in = ($urandom_range(0, 99) < p_ready);
  endtask

  // Sample on the falling edge, let the rising edge happen, then drive the next inputs.
  task automatic step();
    @(negedge clk);
    s_vo   = bus.valid_out;
    s_do   = bus.data_out;
    s_ro   = bus.ready_out;
    s_ri   = bus.ready_in;
    s_vi   = bus.valid_in;
    s_acc  = bus.valid_in && bus.ready_out;
    s_xfer = bus.valid_out && bus.ready_in;
    if (s_acc) void'(tx_q.pop_front());
    if (s_xfer) rx_q.push_back(bus.data_out);
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int n, input int budget);
    int cyc = 0;
    while (rx_q.size() < n && cyc < budget) begin
      step();
      cyc++;
    end
  endtask

  task automatic push_vec(input block_t v);
    for (int i = 0; i < NCBPS; i++) tx_q.push_back(v[NCBPS-1-i]);
  endtask

  function automatic block_t take_block();
    block_t v;
    for (int i = 0; i < NCBPS; i++) begin
      if (rx_q.size() > 0) v[NCBPS-1-i] = rx_q.pop_front();
      else v[NCBPS-1-i] = 1'bx;
    end
    return v;
  endfunction

  function automatic block_t rand_block();
    block_t v;
    for (int i = 0; i < NCBPS / 32; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Output position k carries input bit j = 12*(k mod 16) + k/16.
  function automatic block_t model(input block_t in_vec);
    block_t o;
    int     j;
    for (int k = 0; k < NCBPS; k++) begin
      j = DEINT_ROWS * (k % DEINT_D) + k / DEINT_D;
      o[NCBPS-1-k] = in_vec[NCBPS-1-j];
    end
    return o;
  endfunction

  task automatic test_reset();
    bus.valid_in = 1'b0;
    bus.data_in  = 1'b0;
    bus.ready_in = 1'b0;
    #1 reset_N = 1'b0;
    #2;
    n_vec++;
    if (bus.data_out !== 1'b0) begin
      n_err++; $display("FAIL reset data_out: got %b, expected 0", bus.data_out);
    end
    n_vec++;
    if (bus.valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset valid_out: got %b, expected 0", bus.valid_out);
    end
    n_vec++;
    if (bus.ready_out !== 1'b1) begin
      n_err++; $display("FAIL reset ready_out: got %b, expected 1", bus.ready_out);
    end
    #20;
    @(negedge clk);
    reset_N = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_block();
    block_t got;
    int acc = 0;
    int cyc = 0;
    p_valid = 100; p_ready = 100;
    push_vec(INTERLEAVER_OUTPUT);
    drive();
    while (acc < NCBPS && cyc < 400) begin
      step(); cyc++;
      if (s_acc) acc++;
    end
    n_vec++;
    if (acc != NCBPS) begin
      n_err++; $display("FAIL single_block accepts: got %0d, expected %0d", acc, NCBPS);
    end
    step();
    n_vec++;
    if (s_vo !== 1'b0) begin
      n_err++; $display("FAIL single_block early valid_out: got %b, expected 0", s_vo);
    end
    step();
    n_vec++;
    if (s_vo !== 1'b1) begin
      n_err++; $display("FAIL single_block latency valid_out: got %b, expected 1", s_vo);
    end
    drain(NCBPS, 400);
    got = take_block();
    n_vec++;
    if (got !== FEC_ENDODER_OUTPUT) begin
      n_err++; $display("FAIL single_block data: got %h, expected %h", got, FEC_ENDODER_OUTPUT);
    end
  endtask

  task automatic test_back_to_back();
    block_t got;
    int run = 0, max_run = 0, stalls = 0, cyc = 0;
    p_valid = 100; p_ready = 100;
    for (int b = 0; b < 3; b++) push_vec(INTERLEAVER_OUTPUT);
    drive();
    while (rx_q.size() < 3 * NCBPS && cyc < 1000) begin
      step(); cyc++;
      run = (s_vo === 1'b1) ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (s_vi && !s_ro) stalls++;
    end
    n_vec++;
    if (max_run != 3 * NCBPS) begin
      n_err++; $display("FAIL b2b valid_out run: got %0d, expected %0d", max_run, 3 * NCBPS);
    end
    n_vec++;
    if (stalls != 0) begin
      n_err++; $display("FAIL b2b input stalls: got %0d, expected 0", stalls);
    end
    for (int b = 0; b < 3; b++) begin
      got = take_block();
      n_vec++;
      if (got !== FEC_ENDODER_OUTPUT) begin
        n_err++; $display("FAIL b2b block %0d: got %h, expected %h", b, got, FEC_ENDODER_OUTPUT);
      end
    end
  endtask

  task automatic test_single_one();
    int     js[3] = '{13, 12, 191};
    int     ps[3] = '{17, 1, 191};
    block_t v, got, exp_v;
    p_valid = 100; p_ready = 100;
    for (int t = 0; t < 3; t++) begin
      v = '0;
      v[NCBPS-1-js[t]] = 1'b1;
      exp_v = '0;
      exp_v[NCBPS-1-ps[t]] = 1'b1;
      push_vec(v);
      drive();
      drain(NCBPS, 400);
      got = take_block();
      n_vec++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL single_one j=%0d: got %h, expected %h", js[t], got, exp_v);
      end
    end
  endtask

  task automatic test_stall();
    block_t v2, v3, got;
    block_t exp_q[$];
    int     acc = 0;
    bit     mark = 0;
    logic   ro_after = 1'b1;
    p_valid = 100; p_ready = 0;
    v2 = rand_block();
    v3 = rand_block();
    push_vec(INTERLEAVER_OUTPUT); exp_q.push_back(FEC_ENDODER_OUTPUT);
    push_vec(v2);                 exp_q.push_back(model(v2));
    push_vec(v3);                 exp_q.push_back(model(v3));
    drive();
    for (int i = 0; i < 400; i++) begin
      step();
      if (mark) begin ro_after = s_ro; mark = 0; end
      if (s_acc) begin
        acc++;
        if (acc == 2 * NCBPS) mark = 1;
      end
    end
    n_vec++;
    if (ro_after !== 1'b0) begin
      n_err++; $display("FAIL stall ready_out after 384th accept: got %b, expected 0", ro_after);
    end
    n_vec++;
    if (acc != 2 * NCBPS) begin
      n_err++; $display("FAIL stall accepts while full: got %0d, expected %0d", acc, 2 * NCBPS);
    end
    p_ready = 100;
    drive();
    step();
    n_vec++;
    if (s_ro !== 1'b0) begin
      n_err++; $display("FAIL stall ready_out at release: got %b, expected 0", s_ro);
    end
    drain(NCBPS, 400);
    n_vec++;
    if (s_ro !== 1'b1) begin
      n_err++; $display("FAIL stall ready_out after drain: got %b, expected 1", s_ro);
    end
    drain(3 * NCBPS, 1000);
    for (int b = 0; b < 3; b++) begin
      got = take_block();
      n_vec++;
      if (got !== exp_q[b]) begin
        n_err++; $display("FAIL stall block %0d: got %h, expected %h", b, got, exp_q[b]);
      end
    end
  endtask

  task automatic test_random();
    block_t v, got;
    block_t exp_q[$];
    logic   prev_vo = 1'b0, prev_ri = 1'b1, prev_do = 1'b0;
    int     cyc = 0;
    p_valid = 50; p_ready = 50;
    for (int b = 0; b < 10; b++) begin
      push_vec(INTERLEAVER_OUTPUT); exp_q.push_back(FEC_ENDODER_OUTPUT);
    end
    for (int b = 0; b < 4; b++) begin
      v = rand_block();
      push_vec(v); exp_q.push_back(model(v));
    end
    drive();
    while (rx_q.size() < 14 * NCBPS && cyc < 20000) begin
      step(); cyc++;
      if (prev_vo === 1'b1 && prev_ri === 1'b0) begin
        n_vec++;
        if (s_vo !== 1'b1 || s_do !== prev_do) begin
          n_err++;
          $display("FAIL random hold at cycle %0d: got valid=%b data=%b, expected valid=1 data=%b",
                   cyc, s_vo, s_do, prev_do);
        end
      end
      prev_vo = s_vo; prev_ri = s_ri; prev_do = s_do;
    end
    n_vec++;
    if (rx_q.size() < 14 * NCBPS) begin
      n_err++; $display("FAIL random timeout: got %0d bits, expected %0d", rx_q.size(), 14 * NCBPS);
    end
    for (int b = 0; b < 14; b++) begin
      got = take_block();
      n_vec++;
      if (got !== exp_q[b]) begin
        n_err++; $display("FAIL random block %0d: got %h, expected %h", b, got, exp_q[b]);
      end
    end
  endtask

  task automatic test_mid_reset();
    block_t got;
    int     acc = 0, cyc = 0, early = 0;
    p_valid = 100; p_ready = 0;
    push_vec(INTERLEAVER_OUTPUT);
    for (int i = 0; i < 100; i++) tx_q.push_back(INTERLEAVER_OUTPUT[NCBPS-1-i]);
    drive();
    while (acc < NCBPS + 100 && cyc < 500) begin
      step(); cyc++;
      if (s_acc) acc++;
    end
    #2 reset_N = 1'b0;
    tx_q.delete();
    rx_q.delete();
    bus.valid_in = 1'b0;
    #1;
    n_vec++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== 1'b0 || bus.ready_out !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset outputs: got valid=%b data=%b ready=%b, expected 0 0 1",
               bus.valid_out, bus.data_out, bus.ready_out);
    end
    #10;
    @(negedge clk);
    reset_N = 1'b1;
    p_ready = 100;
    push_vec(INTERLEAVER_OUTPUT);
    @(posedge clk);
    #1;
    drive();
    acc = 0; cyc = 0;
    while (rx_q.size() < NCBPS && cyc < 600) begin
      step(); cyc++;
      if (s_vo === 1'b1 && acc < NCBPS) early++;
      if (s_acc) acc++;
    end
    n_vec++;
    if (early != 0) begin
      n_err++; $display("FAIL mid_reset early output cycles: got %0d, expected 0", early);
    end
    for (int i = 0; i < 30; i++) step();
    n_vec++;
    if (rx_q.size() != NCBPS) begin
      n_err++; $display("FAIL mid_reset output count: got %0d, expected %0d", rx_q.size(), NCBPS);
    end
    got = take_block();
    n_vec++;
    if (got !== FEC_ENDODER_OUTPUT) begin
      n_err++; $display("FAIL mid_reset data: got %h, expected %h", got, FEC_ENDODER_OUTPUT);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_single_one();
    test_stall();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wimax_deinterleaver.md
WIMAX_DEINTERLEAVER -- requirements
Module: wimax_deinterleaver

Interface
REQ-001 clk  input  1  block clock, 100 MHz domain; all state updates on rising edge.
REQ-002 reset_N  input  1  asynchronous, active-low reset.
REQ-003 data_in  input  1  serial interleaved hard bit from the QPSK demapper.
REQ-004 valid_in  input  1  data_in qualifier from upstream.
REQ-005 ready_out  output  1  block can accept data_in; a bit transfers when valid_in && ready_out.
REQ-006 data_out  output  1  serial deinterleaved bit toward the FEC decoder.
REQ-007 valid_out  output  1  data_out qualifier.
REQ-008 ready_in  input  1  downstream ready; a bit transfers when valid_out && ready_in.

Function
REQ-009 The block SHALL process 192-bit blocks for QPSK 1/2, with Ncbps=192, d=16, s=1.
REQ-010 Input bit j (0..191, arrival order) SHALL be written to bank address k = 16*(j mod 12) + floor(j/12); the address comes from a row counter r (0..11) and a column counter c (0..15), with k = 16*r + c and j = 12*c + r.
REQ-011 Example mappings: j=0->k=0, j=1->16, j=11->176, j=12->1, j=13->17, j=191->191.
REQ-012 The block SHALL have two 192-bit banks (ping-pong); the write side fills one bank while the read side drains the other.
REQ-013 Each bank SHALL have a full flag; the flag sets on the cycle the j=191 write completes and clears on the cycle the k=191 read transfers.
REQ-014 ready_out SHALL be 1 exactly when the current write bank is not full.
REQ-015 The read side SHALL output addresses k=0..191 in ascending order from the oldest full bank.
REQ-016 data_out and valid_out SHALL be registered.
REQ-017 valid_out SHALL first rise on the cycle after the write of j=191 completes (latency: 1 cycle from last input accept).
REQ-018 While valid_out=1 and ready_in=0, data_out and valid_out SHALL hold stable; the read address SHALL not advance.
REQ-019 When ready_in and valid_in are held high, throughput SHALL be 1 bit/cycle sustained, with no bubble at block boundaries.
REQ-020 Completing a write to one bank and reading the last bit of the other bank in the same cycle SHALL both take effect in that cycle.
REQ-021 When both banks are full, ready_out SHALL be 0, and input SHALL be ignored regardless of valid_in.
REQ-022 valid_in=0 SHALL freeze the write counters; gaps of any length SHALL NOT corrupt the block.
REQ-023 The write bank pointer and read bank pointer SHALL each toggle only on completion of their respective 192-bit block.

Reset
REQ-024 On reset_N=0, the block SHALL immediately clear r, c, the read address, both bank pointers and both full flags.
REQ-025 On reset_N=0, data_out=0, valid_out=0 and ready_out=1.
REQ-026 Reset mid-block SHALL discard all partial and full blocks; the first bit accepted after reset SHALL be j=0.
REQ-027 Bank contents need not be reset.

Structure
REQ-028 The shared package SHALL hold these constants:
- NCBPS=192, DEINT_D=16, DEINT_ROWS=12;
- test vectors INTERLEAVER_OUTPUT and FEC_ENDODER_OUTPUT (192 bits each).
REQ-029 One sub-module, deint_bank_ram, SHALL implement the two 192x1 banks: 1 write port and 1 read port, with separate bank select for each port.
REQ-030 The address generation and handshake control SHALL stay in the top module, with no further hierarchy.

Verification
REQ-031 Serial bits of a vector SHALL be fed and compared MSB-first: stream bit 0 = vector bit 191.
REQ-032 Reset, then stream INTERLEAVER_OUTPUT with valid_in=1 and ready_in=1 -> the 192 output bits SHALL equal FEC_ENDODER_OUTPUT, and valid_out SHALL rise 1 cycle after the 192nd accept.
REQ-033 Three back-to-back blocks with ready_in=1 -> valid_out SHALL stay 1 for 576 consecutive cycles, and each block SHALL match FEC_ENDODER_OUTPUT.
REQ-034 Single-one pattern, with only input bit j=13 set -> the only 1 at the output SHALL be at output position 17; repeat for j=12 (expected position 1) and j=191 (expected position 191).
REQ-035 ready_in=0 for 400 cycles while 2 blocks are streamed in -> ready_out SHALL fall after the 384th accept; then release ready_in -> both blocks SHALL come out in order and correct, and ready_out SHALL return to 1 after the first block drains.
REQ-036 Random valid_in and ready_in (50% each), 10 blocks -> all blocks SHALL match FEC_ENDODER_OUTPUT, and data_out SHALL never change while valid_out=1 and ready_in=0.
REQ-037 Assert reset_N=0 after 100 bits of a block, then resend the full vector -> no output SHALL appear before the 192nd new accept, and the output SHALL match FEC_ENDODER_OUTPUT.
